// File: rtl/run_ctrl_if.sv
// run_ctrl_if: control/status bundle between the run
// controller and whoever sequences the search engine.
interface run_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             stop;
  logic             eng_done;
  logic [CNT_W-1:0] max_cycles;
  logic             eng_rst_n;
  logic             eng_clk_en;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output start,
    output stop,
    output eng_done,
    output max_cycles,
    input  eng_rst_n,
    input  eng_clk_en,
    input  busy,
    input  done,
    input  timeout,
    input  cycle_count
  );

  modport slave (
    input  start,
    input  stop,
    input  eng_done,
    input  max_cycles,
    output eng_rst_n,
    output eng_clk_en,
    output busy,
    output done,
    output timeout,
    output cycle_count
  );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: start/stop/resume sequencer for the search
// engine clock domain, metering run length against a budget.
module run_ctrl #(
  parameter int RST_HOLD_CYCLES = 4,
  parameter int CNT_W           = 32
) (
  input logic       clk,
  input logic       reset,
  run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_REL,
    S_RUN,
    S_PAUSE,
    S_FIN
  } state_t;

  localparam logic [7:0] HOLD_INIT =
    8'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           r_state;
  logic [7:0]       r_hold;
  logic [CNT_W-1:0] r_budget;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rst_n;
  logic             r_clk_en;
  logic             r_busy;
  logic             r_done;
  logic             r_timeout;

  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_sat;
  logic             w_budget_hit;

  assign w_cnt_inc = r_cnt + ONE;
  assign w_cnt_sat = (&r_cnt) ? r_cnt : w_cnt_inc;
  // Saturated count wraps w_cnt_inc to 0, never a live budget.
  assign w_budget_hit = (r_budget != '0) &&
                        (w_cnt_inc == r_budget);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_hold    <= '0;
      r_budget  <= '0;
      r_cnt     <= '0;
      r_rst_n   <= 1'b0;
      r_clk_en  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_FIN: begin
          if (bus.start) begin
            r_state   <= S_HOLD;
            r_hold    <= HOLD_INIT;
            r_budget  <= bus.max_cycles;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_rst_n   <= 1'b0;
            r_clk_en  <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_HOLD: begin
          if (r_hold != 8'd0) begin
            r_hold <= r_hold - 8'd1;
          end else begin
            r_state  <= S_REL;
            r_rst_n  <= 1'b1;
            r_clk_en <= 1'b0;
          end
        end
        S_REL: begin
          r_state  <= S_RUN;
          r_clk_en <= 1'b1;
        end
        S_RUN: begin
          r_cnt <= w_cnt_sat;
          if (bus.eng_done) begin
            r_state  <= S_FIN;
            r_done   <= 1'b1;
            r_clk_en <= 1'b0;
            r_busy   <= 1'b0;
          end else if (w_budget_hit) begin
            r_state   <= S_FIN;
            r_timeout <= 1'b1;
            r_clk_en  <= 1'b0;
            r_busy    <= 1'b0;
          end else if (bus.stop) begin
            r_state  <= S_PAUSE;
            r_clk_en <= 1'b0;
          end
        end
        S_PAUSE: begin
          if (bus.start) begin
            r_state  <= S_RUN;
            r_clk_en <= 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_rst_n   <= 1'b0;
          r_clk_en  <= 1'b0;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_timeout <= 1'b0;
          r_cnt     <= '0;
        end
      endcase
    end
  end

  assign bus.eng_rst_n   = r_rst_n;
  assign bus.eng_clk_en  = r_clk_en;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.cycle_count = r_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized run scenarios against an outcome
// model, with a scoreboard monitor checking each finish.
module tb_run_ctrl;
  localparam int H = 4;
  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  run_ctrl_if #(.CNT_W(W)) bus ();

  run_ctrl #(
    .RST_HOLD_CYCLES(H),
    .CNT_W(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         d;
    bit         t;
    logic [W-1:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_pop  = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, req);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [63:0] outs();
    return {27'd0, bus.eng_rst_n, bus.eng_clk_en,
            bus.busy, bus.done, bus.timeout,
            bus.cycle_count};
  endfunction

  // Outcome model: whichever of engine-done or budget comes
  // first ends the run; a tie goes to engine-done.
  task automatic run_scn(input int b, input int d,
                         input int p, input int w,
                         input bit ign, input bit both);
    exp_t e;
    int   lim;
    if (d != 0 && (b == 0 || d <= b)) begin
      e.d = 1'b1;
      lim = d;
    end else begin
      e.d = 1'b0;
      lim = b;
    end
    e.t = !e.d;
    e.c = W'(lim);
    if (p >= lim) p = 0;
    exp_q.push_back(e);
    n_push++;

    bus.max_cycles = W'(b);
    bus.start = 1'b1;
    bus.stop  = 1'($urandom_range(0, 1));
    tick;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.max_cycles = W'($urandom);
    repeat (H + 1) tick;

    for (int k = 1; k <= lim; k++) begin
      if (ign && k == 1 && p != 1) bus.start = 1'b1;
      if (p != 0 && k == p) begin
        bus.stop = 1'b1;
        if (both) bus.start = 1'b1;
      end
      if (k == d) bus.eng_done = 1'b1;
      tick;
      bus.start    = 1'b0;
      bus.stop     = 1'b0;
      bus.eng_done = 1'b0;
      if (p != 0 && k == p) begin
        for (int j = 0; j < w; j++) begin
          bus.stop     = 1'($urandom_range(0, 1));
          bus.eng_done = 1'($urandom_range(0, 1));
          tick;
        end
        bus.eng_done = 1'b0;
        bus.start    = 1'b1;
        bus.stop     = 1'($urandom_range(0, 1));
        tick;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
      end
    end

    for (int j = 0; j < 3; j++) begin
      bus.eng_done = 1'($urandom_range(0, 1));
      bus.stop     = 1'($urandom_range(0, 1));
      tick;
    end
    bus.eng_done = 1'b0;
    bus.stop     = 1'b0;
  endtask

  // Monitor: per-cycle protocol checks and scoreboard pop
  // whenever the controller drops busy into FINISH.
  initial begin
    bit   p_busy = 1'b0;
    bit   p_hold = 1'b0;
    bit   p_rn   = 1'b0;
    bit   p_ce   = 1'b0;
    logic [W-1:0] p_cnt = '0;
    int   hold_n = 0;
    int   en_n   = 0;
    bit   hold;
    bit   runc;
    bit   pz;
    exp_t e;
    forever begin
      @(negedge clk);
      hold = !bus.eng_rst_n && bus.eng_clk_en;
      runc = bus.eng_rst_n && bus.eng_clk_en;
      pz   = bus.busy && bus.eng_rst_n && !bus.eng_clk_en;
      if (mon_en) begin
        chk("excl", 64'(bus.done & bus.timeout), 64'd0);
        if (hold && !p_hold) begin
          hold_n = 0;
          en_n   = 0;
          chk("launch_clr",
              {30'd0, bus.done, bus.timeout, bus.cycle_count},
              64'd0);
        end
        if (hold) hold_n++;
        if (runc) begin
          if (en_n == 0)
            chk("hold_rel",
                64'({hold_n, p_rn & !p_ce & p_busy}),
                64'({H, 1'b1}));
          chk("run_cnt", 64'(bus.cycle_count), 64'(en_n));
          en_n++;
        end
        if (pz && p_busy && p_rn && !p_ce && en_n > 0)
          chk("pause_frz", 64'(bus.cycle_count), 64'(p_cnt));
        if (p_busy && !bus.busy) begin
          if (exp_q.size() == 0) begin
            chk("sb_empty", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            n_pop++;
            chk("fin_done", 64'(bus.done), 64'(e.d));
            chk("fin_tmo", 64'(bus.timeout), 64'(e.t));
            chk("fin_cnt", 64'(bus.cycle_count), 64'(e.c));
            chk("fin_en", 64'(bus.cycle_count), 64'(en_n));
            chk("fin_eng",
                64'({bus.eng_rst_n, bus.eng_clk_en}),
                64'(2'b10));
          end
        end
      end
      p_busy = bus.busy;
      p_hold = hold;
      p_rn   = bus.eng_rst_n;
      p_ce   = bus.eng_clk_en;
      p_cnt  = bus.cycle_count;
    end
  end

  initial begin
    int b;
    int d;
    int lim;
    int p;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.eng_done   = 1'b0;
    bus.max_cycles = '0;
    repeat (3) tick;
    chk("rst_state", outs(), 64'd0);
    reset = 1'b1;
    tick;
    chk("idle_state", outs(), 64'd0);
    mon_en = 1'b1;

    run_scn(0, 100, 0, 0, 1'b0, 1'b0);
    run_scn(10, 0, 0, 0, 1'b0, 1'b0);
    run_scn(10, 10, 0, 0, 1'b0, 1'b0);
    run_scn(0, 8, 5, 20, 1'b0, 1'b0);
    run_scn(0, 20, 0, 0, 1'b1, 1'b0);
    run_scn(0, 15, 4, 6, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a run.
    mon_en = 1'b0;
    bus.max_cycles = '0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (H + 1) tick;
    repeat (37) tick;
    chk("pre_rst_cnt", 64'(bus.cycle_count), 64'd37);
    #2 reset = 1'b0;
    #1 chk("async_rst", outs(), 64'd0);
    tick;
    tick;
    chk("rst_held", outs(), 64'd0);
    reset = 1'b1;
    tick;
    chk("post_rst", outs(), 64'd0);
    tick;
    mon_en = 1'b1;

    for (int i = 0; i < 30; i++) begin
      b = ($urandom_range(0, 3) == 0) ?
          0 : int'($urandom_range(3, 40));
      d = (b != 0 && $urandom_range(0, 2) == 0) ?
          0 : int'($urandom_range(1, 45));
      lim = (d != 0 && (b == 0 || d <= b)) ? d : b;
      p = (lim > 2 && $urandom_range(0, 1) == 1) ?
          int'($urandom_range(1, lim - 1)) : 0;
      run_scn(b, d, p, int'($urandom_range(1, 12)),
              1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end

    repeat (5) tick;
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    chk("runs", 64'(n_pop), 64'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
